// File: rtl/excp_commit.sv
// Exception-commit stage: builds the cp0 exception vector from MEM-stage flags and runs the flush/redirect FSM.
// Data-address alignment checking (AdELD/AdES, bad vaddr) is enabled by defining EXCP_DATA_ALIGN_CHECK_EN.
module excp_commit #(
    parameter int unsigned FLUSH_CYCLES      = 1,
    parameter logic [31:0] RESET_REDIRECT_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic        in_delayslot,
    input  logic        in_excp_adeli,
    input  logic        in_excp_ri,
    input  logic        in_excp_ov,
    input  logic        in_excp_sys,
    input  logic        in_excp_bp,
    input  logic        in_eret,
    input  logic        in_mem_en,
    input  logic        in_mem_wr,
    input  logic [1:0]  in_mem_size,
    input  logic [31:0] in_mem_addr,
    input  logic        stall,
    input  logic        exception_i,
    input  logic [31:0] return_pc_i,
    output logic [31:0] exception_type_o,
    output logic [31:0] pc_o,
    output logic        in_delayslot_o,
    output logic [31:0] mem_bad_vaddr_o,
    output logic        mem_kill,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

`ifdef EXCP_DATA_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        misaligned;
    logic        data_excp;
    logic [31:0] vec;

    always_comb begin
        misaligned = 1'b0;
        unique case (in_mem_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = in_mem_addr[0];
            default: misaligned = |in_mem_addr[1:0];
        endcase
    end

    // Fetch/decode faults take precedence over any data-side fault.
    assign data_excp = ALIGN_EN & in_mem_en & misaligned & ~in_excp_adeli & ~in_excp_ri;

    always_comb begin
        vec     = '0;
        vec[4]  = in_excp_adeli;
        vec[5]  = data_excp & ~in_mem_wr;
        vec[6]  = data_excp & in_mem_wr;
        vec[8]  = in_excp_sys;
        vec[9]  = in_excp_bp;
        vec[10] = in_excp_ri;
        vec[12] = in_excp_ov;
        vec[31] = in_eret & ~(|vec[30:0]);
    end

    assign mem_kill = (in_valid & ((|vec) | in_eret)) | busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= 4'd0;
            exception_type_o <= '0;
            pc_o             <= '0;
            in_delayslot_o   <= 1'b0;
            mem_bad_vaddr_o  <= '0;
            flush            <= 1'b0;
            busy             <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= RESET_REDIRECT_PC;
        end else begin
            redirect_valid <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (exception_i) begin
                        // Clearing here guarantees cp0 sees the vector for exactly one negedge.
                        state_reg        <= FLUSH;
                        cnt_reg          <= CNT_INIT;
                        exception_type_o <= '0;
                        flush            <= 1'b1;
                        busy             <= 1'b1;
                        redirect_valid   <= 1'b1;
                        redirect_pc      <= return_pc_i;
                    end else if (!stall) begin
                        exception_type_o <= in_valid ? vec : 32'h0;
                        // Bubbles keep the last PC so an interrupt taken on an empty slot has a real EPC.
                        if (in_valid) begin
                            pc_o            <= in_pc;
                            in_delayslot_o  <= in_delayslot;
                            mem_bad_vaddr_o <= ALIGN_EN ? in_mem_addr : 32'h0;
                        end
                    end
                end
                FLUSH: begin
                    exception_type_o <= '0;
                    if (cnt_reg == 4'd0) begin
                        state_reg <= IDLE;
                        flush     <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/excp_commit.md
# excp_commit

Exception-commit stage between the memory stage and `cp0`. Collects per-instruction exception flags, performs data-address alignment checks, and registers the commit slot that drives `cp0`'s `exception_type_i`, `pc`, `in_delayslot` and `mem_bad_vaddr`. It consumes `cp0`'s `exception` and `return_pc` to run a flush/redirect FSM for the front end and pipeline registers.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: cycles `flush` stays high per exception/ERET; legal range 1–15.
- `RESET_REDIRECT_PC`, default 32'h0000_0000: `redirect_pc` value after reset.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: MEM-stage instruction is valid.
- `in_pc` in 32: its PC.
- `in_delayslot` in 1: it is in a branch delay slot.
- `in_excp_adeli` in 1: fetch address error.
- `in_excp_ri` in 1: reserved instruction.
- `in_excp_ov` in 1: overflow.
- `in_excp_sys` in 1: syscall.
- `in_excp_bp` in 1: break.
- `in_eret` in 1: ERET.
- `in_mem_en` in 1: data access.
- `in_mem_wr` in 1: access is a store.
- `in_mem_size` in 2: 0 byte, 1 half, 2 word, 3 treated as word.
- `in_mem_addr` in 32: data virtual address.
- `stall` in 1: hold commit slot.
- `exception_i` in 1: from `cp0` `exception`.
- `return_pc_i` in 32: from `cp0` `return_pc`.
- `exception_type_o` out 32: to `cp0` `exception_type_i`.
- `pc_o` out 32: to `cp0` `pc`.
- `in_delayslot_o` out 1: to `cp0` `in_delayslot`.
- `mem_bad_vaddr_o` out 32: to `cp0` `mem_bad_vaddr`.
- `mem_kill` out 1: combinational; suppresses the data-memory request this cycle.
- `flush` out 1: clear all upstream pipeline registers.
- `redirect_valid` out 1: one-cycle fetch-redirect strobe.
- `redirect_pc` out 32: fetch target.
- `busy` out 1: FSM is in the FLUSH state.

## Operation
- Vector bit map:
  - 0 INT: always driven 0; `cp0` inserts INT itself.
  - 4 AdELI, 5 AdELD, 6 AdES.
  - 8 Sys, 9 Bp, 10 RI, 12 Ov.
  - 31 ERET.
  - All other bits are 0.
- Misalignment: half with `addr[0]`=1; word/size-3 with `addr[1:0]`≠0; byte accesses never misalign.
- `in_mem_en` & misaligned sets AdES when `in_mem_wr`=1, otherwise AdELD.
- Data checks are suppressed when `in_excp_adeli` or `in_excp_ri` is set.
- ERET bit is set only when no other exception bit is set.
- `mem_kill` = `in_valid` & (any computed exception bit or `in_eret`) | `busy`.
- Commit register load, at posedge:
  - IDLE, `stall`=0: loads the computed vector gated by `in_valid`, plus `in_pc`, `in_delayslot`, and `in_mem_addr` into `mem_bad_vaddr_o`.
  - IDLE, `stall`=1: holds.
  - Bubble (`in_valid`=0): zeroes the vector only; `pc_o`/`in_delayslot_o` keep the last valid values so an interrupt EPC is meaningful.
- FSM states IDLE, FLUSH, plus a 4-bit down-counter.
  - IDLE & `exception_i`=1 at posedge → FLUSH.
  - On that edge: `redirect_pc`←`return_pc_i`, `redirect_valid`=1, commit vector cleared (overrides `stall`), counter←`FLUSH_CYCLES`-1.
  - FLUSH: `flush`=1; counter==0 at posedge → IDLE, otherwise decrement.
  - In FLUSH the commit register loads bubbles and `exception_i` is ignored.
- `redirect_valid` is high only for the first FLUSH cycle.

## Timing
- Reset values: all outputs 0, except `redirect_pc`=`RESET_REDIRECT_PC`; FSM IDLE, counter 0.
- Commit-slot latency: MEM inputs are visible on `*_o` 1 cycle after the posedge that samples them.
- `cp0` commits on the following negedge; `exception_i` is then sampled at the next posedge.
- `flush`/`redirect_valid` rise 1 cycle after the exception vector is presented.
- Vector is cleared on that same edge, so `cp0` sees each exception for exactly one negedge.
- Interrupt with an empty slot (vector 0, `exception_i`=1) follows the same flush path.
- `stall` and exception on the same edge: exception wins.
- Reset mid-FLUSH: outputs return to reset values immediately (asynchronous).

## Configuration
- `EXCP_DATA_ALIGN_CHECK_EN` defined: alignment checking as above.
- Undefined: bits 5/6 are forced to 0, `mem_bad_vaddr_o` is tied to 0, and `mem_kill` ignores alignment.

## Test plan
- Reset: assert `rst`=0 mid-flush → all outputs 0 at once; `redirect_pc`=`RESET_REDIRECT_PC`.
- Word load with `in_mem_addr`=32'h8000_0002, `in_pc`=32'hbfc0_0100:
  - next cycle `exception_type_o`=32'h20, `mem_bad_vaddr_o`=32'h8000_0002, `mem_kill`=1 in the input cycle;
  - after `exception_i`=1 and `return_pc_i`=32'hbfc0_0380: `redirect_pc`=32'hbfc0_0380, `flush` for 1 cycle.
- Half store at 32'h1001 with `in_excp_ri`=1 → vector 32'h400, no AdES.
- ERET together with `in_excp_sys` → vector 32'h100 (no bit 31); ERET alone → 32'h8000_0000.
- `FLUSH_CYCLES`=3, exception with `stall`=1 held:
  - `flush` high 3 cycles, `redirect_valid` 1 cycle, `busy` 3 cycles;
  - vector cleared despite `stall`;
  - second `exception_i` pulse during FLUSH ignored.
- Macro undefined: word load at 32'h3 → vector 0, `mem_kill`=0, `mem_bad_vaddr_o`=0.
